// File: rtl/led_frame_scheduler_pkg.sv
// Shared types and elaboration helpers for the LED frame scheduler.
package led_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE_S = 3'd0,
    VIS_S  = 3'd1,
    HAND_S = 3'd2,
    SEND_S = 3'd3,
    HOLD_S = 3'd4
  } sched_state_t;

  function automatic int frame_cycles(input int freq, input int frame_hz);
    return freq / frame_hz;
  endfunction

  // Counter width for a count range of n values; never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Control-only link between the scheduler, the note pipeline, LinearVisualizer and LEDDriver2.
interface led_frame_scheduler_if;
  // notes_v is a one-cycle strobe. vis_start/drv_start are start levels held until the
  // stage answers: vis_data_v (level) means the visualizer's output is valid, drv_done low
  // means the driver has taken the frame, drv_done high again means it is idle.
  logic notes_v;
  logic vis_start;
  logic vis_data_v;
  logic drv_start;
  logic drv_done;

  modport master (
    input  notes_v,
    input  vis_data_v,
    input  drv_done,
    output vis_start,
    output drv_start
  );

  modport slave (
    output notes_v,
    output vis_data_v,
    output drv_done,
    input  vis_start,
    input  drv_start
  );
endinterface

// File: rtl/led_frame_scheduler_sat_counter.sv
// Up-counter with synchronous clear that stops at MAX instead of wrapping.
module sat_counter #(
  parameter int         W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame sequencer: one visualizer pass then one LED refresh per note set, rate limited,
// with overrun counting and a per-frame watchdog.
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int FREQ        = 12_500_000,
  parameter int FRAME_HZ    = 60,
  parameter int TIMEOUT_CYC = FREQ / 50,
  parameter int DROP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  led_frame_scheduler_if.master bus,
  output logic                  busy,
  output logic                  frame_pulse,
  output logic [DROP_W-1:0]     dropped,
  output logic                  err_timeout,
  output sched_state_t          dbg_state
);

  localparam int FRAME_CYC = frame_cycles(FREQ, FRAME_HZ);
  localparam int FT_W      = cnt_width(FRAME_CYC);
  localparam int WD_W      = cnt_width(TIMEOUT_CYC);
  localparam logic [FT_W-1:0] FT_MAX = FT_W'(FRAME_CYC - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  sched_state_t    state;
  sched_state_t    next_state;
  logic            pending;
  logic            pending_n;
  logic            drop_inc;
  logic            vis_entry;
  logic            active;
  logic            wd_hit;
  logic [FT_W-1:0] ft_q;
  logic [WD_W-1:0] wd_q;

  assign dbg_state = state;

  always_comb begin
    next_state = state;
    pending_n  = pending;
    drop_inc   = 1'b0;
    active     = (state == VIS_S) || (state == HAND_S) || (state == SEND_S);
    wd_hit     = active && (wd_q >= WD_MAX);

    case (state)
      IDLE_S: if (bus.notes_v || pending) next_state = VIS_S;
      VIS_S:  if (bus.vis_data_v)         next_state = HAND_S;
      HAND_S: if (!bus.drv_done)          next_state = SEND_S;
      SEND_S: if (bus.drv_done)           next_state = HOLD_S;
      HOLD_S: if (ft_q >= FT_MAX)         next_state = pending ? VIS_S : IDLE_S;
      default:                            next_state = IDLE_S;
    endcase

    // A hung stage abandons the frame; a queued note set survives the abort.
    if (wd_hit) next_state = IDLE_S;

    vis_entry = (next_state == VIS_S) && (state != VIS_S);

    // Entering VIS consumes the queued set; a strobe on a HOLD->VIS edge re-queues.
    if (vis_entry) begin
      pending_n = (state != IDLE_S) && bus.notes_v;
    end else if (bus.notes_v && (state != IDLE_S)) begin
      pending_n = 1'b1;
      drop_inc  = pending;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE_S;
      pending       <= 1'b0;
      bus.vis_start <= 1'b0;
      bus.drv_start <= 1'b0;
      busy          <= 1'b0;
      frame_pulse   <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= next_state;
      pending       <= pending_n;
      bus.vis_start <= (next_state == VIS_S) || (next_state == HAND_S);
      bus.drv_start <= (next_state == HAND_S);
      busy          <= (next_state != IDLE_S);
      frame_pulse   <= (state == SEND_S) && (next_state == HOLD_S);
      if (wd_hit) err_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(FT_W), .MAX(FT_MAX)) u_frame_timer (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (vis_entry),
    .q   (ft_q)
  );

  sat_counter #(.W(WD_W), .MAX(WD_MAX)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .en  (active),
    .clr (vis_entry),
    .q   (wd_q)
  );

  sat_counter #(.W(DROP_W)) u_dropped (
    .clk (clk),
    .rst (rst),
    .en  (drop_inc),
    .clr (1'b0),
    .q   (dropped)
  );

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: table vectors, directed corner sequences and random traffic.
module tb_led_frame_scheduler;
  import led_frame_scheduler_pkg::*;

  localparam int FREQ        = 1000;
  localparam int FRAME_HZ    = 100;
  localparam int TIMEOUT_CYC = 40;
  localparam int DROP_W      = 2;
  localparam int FRAME_CYC   = FREQ / FRAME_HZ;
  localparam int DROP_MAX    = (1 << DROP_W) - 1;
  localparam int OUT_W       = 10;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              busy;
  logic              frame_pulse;
  logic [DROP_W-1:0] dropped;
  logic              err_timeout;
  sched_state_t      dbg_state;

  led_frame_scheduler_if bus ();

  led_frame_scheduler #(
    .FREQ(FREQ), .FRAME_HZ(FRAME_HZ), .TIMEOUT_CYC(TIMEOUT_CYC), .DROP_W(DROP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .frame_pulse (frame_pulse),
    .dropped     (dropped),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int               n_vec = 0;
  int               n_err = 0;
  logic [OUT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] dut_out();
    return {dbg_state, bus.vis_start, bus.drv_start, busy, frame_pulse, dropped, err_timeout};
  endfunction

  // ---------------- reference model ----------------
  // Timers are expressed as elapsed edges since the frame start, not as counters.
  sched_state_t m_state;
  logic         m_pend, m_err, m_vis, m_drv, m_busy, m_fp;
  int           m_drop;
  int           m_start;
  int           cyc = 0;

  function automatic void model_reset();
    m_state = IDLE_S; m_pend = 1'b0; m_err = 1'b0; m_drop = 0; m_start = 0;
    m_vis = 1'b0; m_drv = 1'b0; m_busy = 1'b0; m_fp = 1'b0;
  endfunction

  function automatic void model_step(input logic nv, input logic vd, input logic dd);
    sched_state_t nxt;
    int   age;
    logic in_frame, was_busy, fp, entry;
    cyc++;
    age      = cyc - m_start;
    was_busy = (m_state != IDLE_S);
    in_frame = (m_state == VIS_S) || (m_state == HAND_S) || (m_state == SEND_S);
    nxt = m_state;
    fp  = 1'b0;
    if (m_state == IDLE_S && (nv || m_pend)) nxt = VIS_S;
    if (m_state == VIS_S && vd) nxt = HAND_S;
    if (m_state == HAND_S && !dd) nxt = SEND_S;
    if (m_state == SEND_S && dd) begin nxt = HOLD_S; fp = 1'b1; end
    if (m_state == HOLD_S && age >= FRAME_CYC) nxt = m_pend ? VIS_S : IDLE_S;
    if (in_frame && age >= TIMEOUT_CYC) begin nxt = IDLE_S; fp = 1'b0; m_err = 1'b1; end
    entry = (nxt == VIS_S) && (m_state != VIS_S);
    if (entry) begin
      m_pend  = was_busy && nv;
      m_start = cyc;
    end else if (nv && was_busy) begin
      if (m_pend && m_drop < DROP_MAX) m_drop++;
      m_pend = 1'b1;
    end
    m_state = nxt;
    m_vis   = (nxt == VIS_S) || (nxt == HAND_S);
    m_drv   = (nxt == HAND_S);
    m_busy  = (nxt != IDLE_S);
    m_fp    = fp;
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    return {m_state, m_vis, m_drv, m_busy, m_fp, DROP_W'(m_drop), m_err};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, let the rising edge happen, compare at the next falling edge.
  task automatic tick(input logic nv, input logic vd, input logic dd);
    bus.notes_v    = nv;
    bus.vis_data_v = vd;
    bus.drv_done   = dd;
    @(posedge clk);
    model_step(nv, vd, dd);
    exp_q.push_back(model_out());
    @(negedge clk);
    check("cycle", dut_out(), exp_q.pop_front());
  endtask

  // Fast downstream stages: visualizer answers next cycle, driver busy for 3 cycles.
  int drv_cnt = 0;
  task automatic env_cycle(input logic nv);
    logic vd_l, dd_l;
    vd_l = bus.vis_start;
    if (bus.drv_start && drv_cnt == 0) drv_cnt = 3;
    dd_l = (drv_cnt == 0);
    if (drv_cnt > 0) drv_cnt--;
    tick(nv, vd_l, dd_l);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (dbg_state != IDLE_S && k < 60) begin
      env_cycle(L);
      k++;
    end
    check(name, dbg_state, IDLE_S);
  endtask

  typedef struct packed {
    logic nv, vd, dd;
    logic [2:0] st;
    logic vis, drv, bsy, fp;
  } vec_t;

  function automatic vec_t mk(input logic nv, input logic vd, input logic dd, input sched_state_t st,
                              input logic vis, input logic drv, input logic bsy, input logic fp);
    return {nv, vd, dd, st, vis, drv, bsy, fp};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[12];
    int   rises, r1, r2, idle_between, fp_cnt, drv_hi, last_rise;
    logic prev_vis, sent, nv, vd;

    tbl[0]  = mk(H, L, H, VIS_S,  H, L, H, L);
    tbl[1]  = mk(L, L, H, VIS_S,  H, L, H, L);
    tbl[2]  = mk(L, L, H, VIS_S,  H, L, H, L);
    tbl[3]  = mk(L, H, H, HAND_S, H, H, H, L);
    tbl[4]  = mk(L, H, L, SEND_S, L, L, H, L);
    tbl[5]  = mk(L, L, L, SEND_S, L, L, H, L);
    tbl[6]  = mk(L, L, L, SEND_S, L, L, H, L);
    tbl[7]  = mk(L, L, L, SEND_S, L, L, H, L);
    tbl[8]  = mk(L, L, H, HOLD_S, L, L, H, H);
    tbl[9]  = mk(L, L, H, HOLD_S, L, L, H, L);
    tbl[10] = mk(L, L, H, IDLE_S, L, L, L, L);
    tbl[11] = mk(L, L, H, IDLE_S, L, L, L, L);

    bus.notes_v = 1'b0; bus.vis_data_v = 1'b0; bus.drv_done = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_out", dut_out(), '0);
    rst = 1'b1;

    // Single frame from the table.
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].nv, tbl[i].vd, tbl[i].dd);
      check("tbl_ctrl", {dbg_state, bus.vis_start, bus.drv_start, busy, frame_pulse},
            {tbl[i].st, tbl[i].vis, tbl[i].drv, tbl[i].bsy, tbl[i].fp});
      check("tbl_drop_err", {dropped, err_timeout}, '0);
    end

    // One strobe during SEND queues the next frame straight out of HOLD.
    sent = 1'b0; rises = 0; r1 = 0; r2 = 0; idle_between = 0; prev_vis = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nv = (i == 0) || (dbg_state == SEND_S && !sent);
      if (dbg_state == SEND_S) sent = 1'b1;
      env_cycle(nv);
      if (bus.vis_start && !prev_vis) begin
        rises++;
        if (rises == 1) r1 = cyc; else if (rises == 2) r2 = cyc;
      end
      if (rises == 1 && dbg_state == IDLE_S) idle_between++;
      prev_vis = bus.vis_start;
    end
    check("pend_frames", rises, 2);
    check("pend_spacing", r2 - r1, FRAME_CYC);
    check("pend_no_idle", idle_between, 0);
    check("pend_dropped", dropped, 0);
    wait_idle("pend_idle");

    // Driver already busy at HAND entry.
    drv_hi = 0;
    tick(H, L, H); if (bus.drv_start) drv_hi++;
    tick(L, H, L); if (bus.drv_start) drv_hi++;
    tick(L, H, L); if (bus.drv_start) drv_hi++;
    check("busy_drv_send", dbg_state, SEND_S);
    tick(L, L, L); if (bus.drv_start) drv_hi++;
    tick(L, L, H); if (bus.drv_start) drv_hi++;
    check("busy_drv_pulse_len", drv_hi, 1);
    wait_idle("busy_drv_idle");

    // Rate limit under a strobe every other cycle.
    rises = 0; last_rise = 0; prev_vis = 1'b0;
    for (int i = 0; i < 70; i++) begin
      env_cycle((i % 2) == 0);
      if (bus.vis_start && !prev_vis) begin
        if (rises > 0) check("rate_spacing", cyc - last_rise, FRAME_CYC);
        rises++;
        last_rise = cyc;
      end
      prev_vis = bus.vis_start;
    end
    check("rate_dropped_sat", dropped, DROP_MAX);
    wait_idle("rate_idle");

    // Watchdog on a visualizer that never answers.
    tick(H, L, H);
    repeat (TIMEOUT_CYC - 1) tick(L, L, H);
    check("wd_before", {dbg_state, err_timeout}, {VIS_S, L});
    tick(L, L, H);
    check("wd_fire", {dbg_state, bus.vis_start, bus.drv_start, err_timeout}, {IDLE_S, L, L, H});
    fp_cnt = 0;
    env_cycle(H);
    for (int i = 0; i < 30; i++) begin
      env_cycle(L);
      if (frame_pulse) fp_cnt++;
    end
    check("wd_recover_frame", fp_cnt, 1);
    check("wd_sticky", err_timeout, 1);

    // Asynchronous reset in the middle of SEND.
    tick(H, L, H);
    tick(L, H, H);
    tick(L, H, L);
    tick(L, L, L);
    check("arst_in_send", dbg_state, SEND_S);
    #2 rst = 1'b0;
    #1 check("arst_out", dut_out(), '0);
    @(posedge clk);
    @(negedge clk);
    bus.notes_v = 1'b0; bus.vis_data_v = 1'b0; bus.drv_done = 1'b1;
    rst = 1'b1;
    model_reset();
    drv_cnt = 0;

    // Random traffic: starved visualizer first, then lively stages.
    for (int i = 0; i < 900; i++) begin
      nv = ($urandom_range(0, 7) == 0);
      vd = (i < 300) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) != 0);
      tick(nv, vd, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
